fft16_power_spectrum: RTL and testbench

- Downstream consumer of the 16-point sequential FFT. Captures the 16 complex output bins streamed on the FFT's Y bus after DONE.
- Computes per-bin power re²+im², scales and saturates it, and applies optional peak-hold decay into a 16-entry spectrum register file.
- Finds the strongest bin in a configurable band.
- Feeds the audio-spectrum display logic, which reads bars through a synchronous read port.

---
 rtl/fft16_power_spectrum.sv | 209 ++++++++++++++++++++
 tb/tb_fft16_power_spectrum.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_power_spectrum.sv
// fft16_power_spectrum
//   Captures the 16 complex bins streamed on Y after the FFT's DONE strobe,
//   computes per-bin power re^2+im^2, scales/saturates it, applies optional
//   peak-hold decay into a 16-entry spectrum register file, and tracks the
//   strongest bin inside [PEAK_LO, PEAK_HI].
//
// Handshake: DONE is a single-cycle start strobe with no back-pressure. The
//   cycle DONE is seen in IDLE carries bin 0 on Y; bins 1..15 follow on the
//   next 15 cycles unconditionally. FRAME_VALID is a one-cycle pulse, no ready.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   DONE, Y               frame start strobe, bin stream {re[31:16], im[15:0]}
//   RD_ADDR, RD_DATA      synchronous spectrum read port (1-cycle latency)
//   FRAME_VALID           pulse one cycle after the last bin is committed
//   PEAK_BIN, PEAK_VAL    strongest in-band bin of the last committed frame
//   BUSY                  frame data held in capture or pipeline
//   OVERRUN, CLR_OVR      sticky flag for DONE during capture, and its clear
module fft16_power_spectrum #(
    parameter int OUT_W     = 16,
    parameter int PWR_SHIFT = 8,
    parameter int DECAY     = 0,
    parameter int PEAK_LO   = 1,
    parameter int PEAK_HI   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DONE,
    input  logic [31:0]      Y,
    input  logic [3:0]       RD_ADDR,
    output logic [OUT_W-1:0] RD_DATA,
    output logic             FRAME_VALID,
    output logic [3:0]       PEAK_BIN,
    output logic [OUT_W-1:0] PEAK_VAL,
    output logic             BUSY,
    output logic             OVERRUN,
    input  logic             CLR_OVR
);

    localparam logic [3:0]       LO4   = 4'(PEAK_LO);
    localparam logic [3:0]       HI4   = 4'(PEAK_HI);
    localparam logic [32:0]      DEC33 = 33'(DECAY);
    localparam logic [OUT_W-1:0] DEC_W = OUT_W'(DECAY);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  bin_cnt, bin_cnt_nxt;
    logic        take;

    // stage1: captured sample
    logic              s1_valid;
    logic signed [31:0] s1_re, s1_im;
    logic [3:0]        s1_bin;
    // stage2: raw power
    logic              s2_valid;
    logic [31:0]       s2_p;
    logic [3:0]        s2_bin;

    logic signed [31:0] re_sq, im_sq;
    logic [31:0]        shifted;
    logic [OUT_W-1:0]   sat_val, old_val, decayed, new_val;
    logic [OUT_W-1:0]   run_val, base_val, cand_val;
    logic [3:0]         run_bin, base_bin, cand_bin;
    logic               in_band;

    logic [OUT_W-1:0] mem [16];

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            bin_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            bin_cnt <= bin_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bin_cnt_nxt = bin_cnt;
        take        = 1'b0;
        case (state)
            IDLE: begin
                if (DONE) begin
                    take        = 1'b1;
                    state_nxt   = CAPTURE;
                    bin_cnt_nxt = 4'd1;
                end
            end
            CAPTURE: begin
                take        = 1'b1;
                bin_cnt_nxt = bin_cnt + 4'd1;
                if (bin_cnt == 4'd15) begin
                    state_nxt   = IDLE;
                    bin_cnt_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                bin_cnt_nxt = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage1 / stage2
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_bin   <= 4'd0;
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_bin   <= 4'd0;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_re  <= 32'($signed(Y[31:16]));
                s1_im  <= 32'($signed(Y[15:0]));
                s1_bin <= bin_cnt;
            end
            s2_valid <= s1_valid;
            s2_bin   <= s1_bin;
            s2_p     <= $unsigned(re_sq) + $unsigned(im_sq);
        end
    end

    // Each square is at most 2^30, so the signed 32-bit products never wrap
    // and their unsigned sum (max 2^31) fits in 32 bits.
    assign re_sq = s1_re * s1_re;
    assign im_sq = s1_im * s1_im;

    // ------------------------------------------------------------------
    // Stage3: scale, saturate, decay, peak search (combinational part)
    // ------------------------------------------------------------------
    always_comb begin
        shifted = s2_p >> PWR_SHIFT;
        // Any bit at or above OUT_W means the value does not fit.
        sat_val = ((shifted >> OUT_W) != 32'd0) ? '1 : shifted[OUT_W-1:0];
        old_val = mem[s2_bin];
        decayed = (33'(old_val) > DEC33) ? (old_val - DEC_W) : '0;
        if (DECAY == 0)
            new_val = sat_val;
        else
            new_val = (sat_val > decayed) ? sat_val : decayed;

        // Bin 0 restarts the running max; the default winner is PEAK_LO/0.
        base_bin = (s2_bin == 4'd0) ? LO4 : run_bin;
        base_val = (s2_bin == 4'd0) ? '0  : run_val;
        in_band  = (s2_bin >= LO4) && (s2_bin <= HI4);
        // Strictly greater keeps the lowest index on ties.
        if (in_band && (new_val > base_val)) begin
            cand_bin = s2_bin;
            cand_val = new_val;
        end else begin
            cand_bin = base_bin;
            cand_val = base_val;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            run_bin     <= 4'd0;
            run_val     <= '0;
            PEAK_BIN    <= 4'd0;
            PEAK_VAL    <= '0;
            FRAME_VALID <= 1'b0;
        end else begin
            FRAME_VALID <= s2_valid && (s2_bin == 4'd15);
            if (s2_valid) begin
                mem[s2_bin] <= new_val;
                run_bin     <= cand_bin;
                run_val     <= cand_val;
                if (s2_bin == 4'd15) begin
                    PEAK_BIN <= cand_bin;
                    PEAK_VAL <= cand_val;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port, overrun flag, busy
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RD_DATA <= '0;
            OVERRUN <= 1'b0;
        end else begin
            RD_DATA <= mem[RD_ADDR];
            // A new overrun wins over a simultaneous clear.
            if ((state == CAPTURE) && DONE)
                OVERRUN <= 1'b1;
            else if (CLR_OVR)
                OVERRUN <= 1'b0;
        end
    end

    // DONE covers the t0 cycle, before the FSM has left IDLE.
    assign BUSY = !RESET && ((state == CAPTURE) || DONE || s1_valid || s2_valid);

endmodule

// File: tb/tb_fft16_power_spectrum.sv
// Bench for fft16_power_spectrum. Two instances run side by side on the same
// stimulus: dut_a with default parameters and dut_b with OUT_W=32,
// PWR_SHIFT=0, DECAY=100. A frame-level model computes every frame's spectrum
// and peak with plain integer arithmetic and schedules cycle-indexed
// expectations for FRAME_VALID, BUSY, OVERRUN and the held peak.
module tb_fft16_power_spectrum;

    localparam int NCYC = 8192;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        DONE = 1'b0;
    logic [31:0] Y = '0;
    logic [3:0]  RD_ADDR = '0;
    logic        CLR_OVR = 1'b0;

    logic [15:0] rd_a, pv_a;
    logic [31:0] rd_b, pv_b;
    logic [3:0]  pb_a, pb_b;
    logic        fv_a, fv_b, busy_a, busy_b, ovr_a, ovr_b;

    fft16_power_spectrum dut_a (
        .CLK(CLK), .RESET(RESET), .DONE(DONE), .Y(Y), .RD_ADDR(RD_ADDR),
        .RD_DATA(rd_a), .FRAME_VALID(fv_a), .PEAK_BIN(pb_a), .PEAK_VAL(pv_a),
        .BUSY(busy_a), .OVERRUN(ovr_a), .CLR_OVR(CLR_OVR)
    );

    fft16_power_spectrum #(.OUT_W(32), .PWR_SHIFT(0), .DECAY(100)) dut_b (
        .CLK(CLK), .RESET(RESET), .DONE(DONE), .Y(Y), .RD_ADDR(RD_ADDR),
        .RD_DATA(rd_b), .FRAME_VALID(fv_b), .PEAK_BIN(pb_b), .PEAK_VAL(pv_b),
        .BUSY(busy_b), .OVERRUN(ovr_b), .CLR_OVR(CLR_OVR)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [31:0] frame_bins [16];
    longint      mdl_mem [2][16];
    int          last_pb [2];
    longint      last_pv [2];
    int          qb0[$], qb1[$];
    longint      qv0[$], qv1[$];
    int          exp_pb [2];
    longint      exp_pv [2];
    bit          exp_ovr = 1'b0;
    bit          exp_fv   [NCYC];
    bit          exp_busy [NCYC];
    byte         ovr_ev   [NCYC];   // 1 = set, 2 = clear, effective that cycle

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic logic [31:0] mk(input int re, input int im);
        logic [15:0] r, i;
        r = 16'(re);
        i = 16'(im);
        return {r, i};
    endfunction

    // Frame-level model: whole frame processed at once from the rules.
    function automatic void model_frame(input int t0);
        int w, sh, dec, pb;
        longint maxv, p, s, o, pv, re, im;
        for (int c = 0; c < 2; c++) begin
            w   = (c == 0) ? 16 : 32;
            sh  = (c == 0) ? 8  : 0;
            dec = (c == 0) ? 0  : 100;
            maxv = (64'sd1 <<< w) - 1;
            for (int k = 0; k < 16; k++) begin
                re = longint'(shortint'(frame_bins[k][31:16]));
                im = longint'(shortint'(frame_bins[k][15:0]));
                p = re * re + im * im;
                s = p >>> sh;
                if (s > maxv) s = maxv;
                if (dec != 0) begin
                    o = mdl_mem[c][k] - dec;
                    if (o < 0) o = 0;
                    if (o > s) s = o;
                end
                mdl_mem[c][k] = s;
            end
            pb = 1;
            pv = 0;
            for (int k = 1; k <= 8; k++)
                if (mdl_mem[c][k] > pv) begin
                    pb = k;
                    pv = mdl_mem[c][k];
                end
            last_pb[c] = pb;
            last_pv[c] = pv;
            if (c == 0) begin qb0.push_back(pb); qv0.push_back(pv); end
            else        begin qb1.push_back(pb); qv1.push_back(pv); end
        end
        for (int t = t0; t <= t0 + 17; t++) if (t < NCYC) exp_busy[t] = 1'b1;
        if (t0 + 18 < NCYC) exp_fv[t0 + 18] = 1'b1;
    endfunction

    function automatic void model_abort(input int now);
        for (int t = now; t < NCYC; t++) begin
            exp_busy[t] = 1'b0;
            exp_fv[t]   = 1'b0;
            ovr_ev[t]   = 0;
        end
        qb0.delete(); qv0.delete(); qb1.delete(); qv1.delete();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 16; k++) mdl_mem[c][k] = 0;
            exp_pb[c] = 0;
            exp_pv[c] = 0;
        end
        exp_ovr = 1'b0;
    endfunction

    // ---------------- per-cycle compare process ----------------
    always @(negedge CLK) begin
        if (cyc < NCYC) begin
            if (ovr_ev[cyc] == 1)      exp_ovr = 1'b1;
            else if (ovr_ev[cyc] == 2) exp_ovr = 1'b0;
            if (exp_fv[cyc]) begin
                if (qb0.size() > 0) begin exp_pb[0] = qb0.pop_front(); exp_pv[0] = qv0.pop_front(); end
                if (qb1.size() > 0) begin exp_pb[1] = qb1.pop_front(); exp_pv[1] = qv1.pop_front(); end
            end
            chk("frame_valid_a", fv_a, exp_fv[cyc]);
            chk("frame_valid_b", fv_b, exp_fv[cyc]);
            chk("busy_a", busy_a, exp_busy[cyc]);
            chk("busy_b", busy_b, exp_busy[cyc]);
            chk("overrun_a", ovr_a, exp_ovr);
            chk("overrun_b", ovr_b, exp_ovr);
            chk("peak_bin_a", pb_a, exp_pb[0]);
            chk("peak_val_a", pv_a, exp_pv[0]);
            chk("peak_bin_b", pb_b, exp_pb[1]);
            chk("peak_val_b", pv_b, exp_pv[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            DONE = 1'b0;
            CLR_OVR = 1'b0;
            Y = $urandom;
        end
    endtask

    // extra: cycle offset of a second DONE inside capture (-1 none)
    // clr_at: offset of a CLR_OVR pulse (-1 none)
    // rst_at: offset at which RESET is asserted, aborting the frame (-1 none)
    task automatic do_frame(input int extra, input int clr_at, input int rst_at, input int gap);
        bit aborted = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(posedge CLK); #1;
            if (k == rst_at) begin
                RESET = 1'b1;
                DONE = 1'b0;
                CLR_OVR = 1'b0;
                model_abort(cyc);
                aborted = 1'b1;
                break;
            end
            DONE = (k == 0) || (k == extra);
            CLR_OVR = (k == clr_at);
            Y = frame_bins[k];
            if (k == 0) model_frame(cyc);
            if (k == clr_at && ovr_ev[cyc + 1] != 1) ovr_ev[cyc + 1] = 2;
            if (k == extra && k != 0) ovr_ev[cyc + 1] = 1;
        end
        if (aborted) begin
            idle(3);
            RESET = 1'b0;
        end
        idle(gap);
    endtask

    task automatic clr_ovr();
        @(posedge CLK); #1;
        DONE = 1'b0;
        CLR_OVR = 1'b1;
        if (ovr_ev[cyc + 1] != 1) ovr_ev[cyc + 1] = 2;
        idle(1);
    endtask

    task automatic sweep();
        idle(3);
        for (int a = 0; a <= 16; a++) begin
            @(posedge CLK); #1;
            DONE = 1'b0;
            CLR_OVR = 1'b0;
            if (a > 0) begin
                chk("rd_a", rd_a, mdl_mem[0][a - 1]);
                chk("rd_b", rd_b, mdl_mem[1][a - 1]);
            end
            if (a < 16) RD_ADDR = 4'(a);
        end
    endtask

    task automatic zero_bins();
        for (int k = 0; k < 16; k++) frame_bins[k] = '0;
    endtask

    task automatic rand_bins();
        int r;
        for (int k = 0; k < 16; k++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: frame_bins[k] = '0;
                1: frame_bins[k] = mk($urandom_range(0, 600) - 300, $urandom_range(0, 600) - 300);
                2: frame_bins[k] = mk($urandom_range(0, 8000) - 4000, $urandom_range(0, 8000) - 4000);
                3: frame_bins[k] = $urandom;
                default: frame_bins[k] = mk(-32768, -32768);
            endcase
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ex, cl;
        for (int t = 0; t < NCYC; t++) begin
            exp_fv[t] = 1'b0; exp_busy[t] = 1'b0; ovr_ev[t] = 0;
        end
        model_abort(0);
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        sweep();

        // single tone
        zero_bins();
        frame_bins[3] = mk(100, 0);
        do_frame(-1, -1, -1, 4);
        sweep();
        chk("pin_tone_b_mem3", mdl_mem[1][3], 10000);
        chk("pin_tone_a_mem3", mdl_mem[0][3], 39);
        chk("pin_tone_b_peak_bin", last_pb[1], 3);
        chk("pin_tone_b_peak_val", last_pv[1], 10000);

        // saturation
        zero_bins();
        frame_bins[5] = mk(-32768, -32768);
        frame_bins[2] = mk(-3, 4);
        do_frame(-1, -1, -1, 4);
        sweep();
        chk("pin_sat_a_mem5", mdl_mem[0][5], 65535);
        chk("pin_sat_a_mem2", mdl_mem[0][2], 0);
        chk("pin_sat_b_mem5", mdl_mem[1][5], 64'd2147483648);

        // band and ties
        zero_bins();
        frame_bins[0] = mk(30000, 0);
        frame_bins[2] = mk(4096, 0);
        frame_bins[6] = mk(4096, 0);
        do_frame(-1, -1, -1, 4);
        sweep();
        chk("pin_band_a_mem0", mdl_mem[0][0], 65535);
        chk("pin_band_a_peak_bin", last_pb[0], 2);
        chk("pin_band_a_peak_val", last_pv[0], 65535);

        // overrun, then clear; then overrun and clear in the same cycle
        rand_bins();
        do_frame(5, -1, -1, 4);
        clr_ovr();
        rand_bins();
        do_frame(7, 7, -1, 4);
        idle(2);
        clr_ovr();

        // back-to-back frames
        rand_bins();
        do_frame(-1, -1, -1, 0);
        rand_bins();
        do_frame(-1, -1, -1, 4);
        sweep();

        // reset mid-frame, then decay sequence from a clean state
        rand_bins();
        do_frame(-1, -1, 8, 2);
        sweep();
        zero_bins();
        frame_bins[4] = mk(31, 7);
        do_frame(-1, -1, -1, 4);
        sweep();
        chk("pin_decay_b_f1", mdl_mem[1][4], 1010);
        chk("pin_decay_a_f1", mdl_mem[0][4], 3);
        zero_bins();
        do_frame(-1, -1, -1, 4);
        sweep();
        chk("pin_decay_b_f2", mdl_mem[1][4], 910);
        do_frame(-1, -1, -1, 4);
        sweep();
        chk("pin_decay_b_f3", mdl_mem[1][4], 810);
        chk("pin_zero_a_peak_bin", last_pb[0], 1);
        chk("pin_zero_a_peak_val", last_pv[0], 0);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            rand_bins();
            ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1;
            cl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1;
            do_frame(ex, cl, -1, $urandom_range(0, 4));
            if (f % 8 == 7) sweep();
        end
        sweep();
        idle(30);
        chk("queue_drained_a", 64'(qb0.size()), 0);
        chk("queue_drained_b", 64'(qb1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
